// File: rtl/fp_stream_reducer.sv
// rtl/fp_stream_reducer.sv - per-frame floating-point sum reducer driving an external pipelined adder
// Partial sums come back through a credit-limited FIFO and are recirculated until one value remains.

module fp_stream_reducer_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_head,
   output logic [CW-1:0] o_count,
   output logic          o_empty,
   output logic          o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

module fp_stream_reducer #(
   parameter string DATA_FORMAT = "FP32",
   parameter int    DEPTH       = 8,
   localparam int   FP_LEN      = (DATA_FORMAT == "FP64") ? 64 :
                                  ((DATA_FORMAT == "FP16") || (DATA_FORMAT == "BF16")) ? 16 : 32
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [FP_LEN-1:0] i_in_data,
   input  logic              i_in_valid,
   input  logic              i_in_last,
   output logic              o_in_ready,
   output logic [FP_LEN-1:0] o_add_a,
   output logic [FP_LEN-1:0] o_add_b,
   output logic              o_add_a_valid,
   output logic              o_add_b_valid,
   input  logic              i_add_a_ready,
   input  logic              i_add_b_ready,
   input  logic [FP_LEN-1:0] i_add_sum,
   input  logic              i_add_sum_valid,
   output logic              o_add_sum_ready,
   output logic [FP_LEN-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {S_ACC, S_OUT} state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic [FP_LEN-1:0] r_op_a;
   logic [FP_LEN-1:0] r_op_b;
   logic              r_op_a_v;
   logic              r_op_b_v;
   logic [FP_LEN-1:0] r_out_data;
   logic              r_last_seen;
   logic [CW-1:0]     r_inflight;

   logic [FP_LEN-1:0] w_fifo_head;
   logic [CW-1:0]     w_fifo_count;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_slot_free;
   logic              w_fill_fifo;
   logic              w_fill_in;
   logic              w_fill;
   logic [FP_LEN-1:0] w_fill_data;
   logic [CW:0]       w_credit_used;
   logic              w_issue_valid;
   logic              w_fire;
   logic              w_ret;
   logic              w_done;
   logic              w_out_fire;

   fp_stream_reducer_fifo #(
      .W     (FP_LEN),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_ret_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (w_ret),
      .i_push_data (i_add_sum),
      .i_pop       (w_fill_fifo),
      .o_head      (w_fifo_head),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

   // Slot availability is taken from registered valids only, so a pair issued this
   // cycle cannot be refilled until the next one.
   assign w_slot_free = !r_op_a_v || !r_op_b_v;
   assign w_fill_fifo = (r_state == S_ACC) && !w_fifo_empty && w_slot_free;
   assign o_in_ready  = !i_reset && (r_state == S_ACC) && !r_last_seen && w_fifo_empty && w_slot_free;
   assign w_fill_in   = i_in_valid && o_in_ready;
   assign w_fill      = w_fill_fifo || w_fill_in;
   assign w_fill_data = w_fill_fifo ? w_fifo_head : i_in_data;

   // Every in-flight add owns a FIFO entry, so the return path can never overflow.
   assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign w_issue_valid = r_op_a_v && r_op_b_v && (w_credit_used < (CW + 1)'(DEPTH));
   assign o_add_a_valid = w_issue_valid;
   assign o_add_b_valid = w_issue_valid;
   assign o_add_a       = r_op_a;
   assign o_add_b       = r_op_b;
   assign w_fire        = w_issue_valid && i_add_a_ready && i_add_b_ready;

   assign o_add_sum_ready = !w_fifo_full;
   assign w_ret           = i_add_sum_valid && o_add_sum_ready;

   assign w_done     = (r_state == S_ACC) && r_last_seen && (r_inflight == '0) &&
                       w_fifo_empty && (r_op_a_v ^ r_op_b_v);
   assign o_out_valid = (r_state == S_OUT);
   assign o_out_data  = r_out_data;
   assign w_out_fire  = o_out_valid && i_out_ready;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_ACC;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_ACC:   if (w_done) w_state_next = S_OUT;
         S_OUT:   if (i_out_ready) w_state_next = S_ACC;
         default: w_state_next = S_ACC;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_a_v    <= 1'b0;
         r_op_b_v    <= 1'b0;
         r_out_data  <= '0;
         r_last_seen <= 1'b0;
         r_inflight  <= '0;
      end else begin
         if (w_fire || w_done) begin
            r_op_a_v <= 1'b0;
            r_op_b_v <= 1'b0;
         end else if (w_fill) begin
            if (!r_op_a_v) begin
               r_op_a   <= w_fill_data;
               r_op_a_v <= 1'b1;
            end else begin
               r_op_b   <= w_fill_data;
               r_op_b_v <= 1'b1;
            end
         end

         if (w_done) r_out_data <= r_op_a_v ? r_op_a : r_op_b;

         if (w_fill_in && i_in_last) r_last_seen <= 1'b1;
         else if (w_out_fire)        r_last_seen <= 1'b0;

         case ({w_fire, w_ret})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_stream_reducer.sv
// tb/tb_fp_stream_reducer.sv - self-checking bench for fp_stream_reducer with a queue-based adder model
// Frame sums are compared against hand-derived constants and against integer sums of random frames.

module tb_fp_stream_reducer;
   localparam int DEPTH = 8;
   localparam int LAT   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_in_data;
   logic        i_in_valid;
   logic        i_in_last;
   logic        o_in_ready;
   logic [31:0] o_add_a;
   logic [31:0] o_add_b;
   logic        o_add_a_valid;
   logic        o_add_b_valid;
   logic        i_add_a_ready;
   logic        i_add_b_ready;
   logic [31:0] i_add_sum;
   logic        i_add_sum_valid;
   logic        o_add_sum_ready;
   logic [31:0] o_out_data;
   logic        o_out_valid;
   logic        i_out_ready;

   fp_stream_reducer #(.DATA_FORMAT("FP32"), .DEPTH(DEPTH)) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_in_data       (i_in_data),
      .i_in_valid      (i_in_valid),
      .i_in_last       (i_in_last),
      .o_in_ready      (o_in_ready),
      .o_add_a         (o_add_a),
      .o_add_b         (o_add_b),
      .o_add_a_valid   (o_add_a_valid),
      .o_add_b_valid   (o_add_b_valid),
      .i_add_a_ready   (i_add_a_ready),
      .i_add_b_ready   (i_add_b_ready),
      .i_add_sum       (i_add_sum),
      .i_add_sum_valid (i_add_sum_valid),
      .o_add_sum_ready (o_add_sum_ready),
      .o_out_data      (o_out_data),
      .o_out_valid     (o_out_valid),
      .i_out_ready     (i_out_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] val; int due; } pend_t;
   typedef struct packed { int n; logic [3:0][31:0] v; logic [31:0] exp_sum; } vec_t;

   pend_t       aq[$];
   logic [32:0] src[$];
   logic [31:0] got[$];
   int          got_iss[$];
   logic [31:0] exp_q[$];
   vec_t        tbl[6];

   int cyc = 0, checks = 0, failures = 0;
   int in_rate = 100, add_rate = 100, out_rate = 100;
   int issues_cur = 0, lasts_acc = 0, outs_done = 0;
   int viol_stable = 0, viol_credit = 0, viol_sumrdy = 0, viol_overlap = 0, viol_pair = 0;
   int acc_cyc = 0, ov_rise_cyc = 0;
   logic prev_issue_stall = 1'b0, prev_out_stall = 1'b0, prev_ov = 1'b0;
   logic [31:0] prev_a, prev_b, prev_out;

   function automatic real fp2real(input logic [31:0] b);
      real m;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] real2fp(input real x);
      logic   s;
      int     e;
      longint mi;
      if (x == 0.0) return 32'h0;
      s = (x < 0.0);
      if (s) x = -x;
      e = 0;
      while (x >= 2.0) begin x = x / 2.0; e++; end
      while (x < 1.0)  begin x = x * 2.0; e--; end
      mi = longint'((x - 1.0) * 8388608.0);
      return {s, 8'(e + 127), 23'(mi)};
   endfunction

   function automatic vec_t mk(input int n, input logic [31:0] e0, e1, e2, e3, input logic [31:0] s);
      vec_t r;
      r.n = n;
      r.v[0] = e0; r.v[1] = e1; r.v[2] = e2; r.v[3] = e3;
      r.exp_sum = s;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 32'hDEADBEEF;
   endfunction

   function automatic int iss_at(input int i);
      return (i < got_iss.size()) ? got_iss[i] : -1;
   endfunction

   // One clock cycle: drive inputs after the falling edge, observe, then advance.
   task automatic cycle();
      logic ardy;
      logic in_fire;
      ardy = ($urandom_range(99) < add_rate);
      i_add_a_ready = ardy;
      i_add_b_ready = ardy;
      if (aq.size() > 0 && aq[0].due <= cyc) begin
         i_add_sum_valid = 1'b1;
         i_add_sum       = aq[0].val;
      end else begin
         i_add_sum_valid = 1'b0;
         i_add_sum       = 32'h0;
      end
      if (!i_in_valid && src.size() > 0 && $urandom_range(99) < in_rate) begin
         i_in_valid = 1'b1;
         {i_in_last, i_in_data} = src.pop_front();
      end
      i_out_ready = ($urandom_range(99) < out_rate);
      #1;
      if (o_add_sum_ready !== 1'b1) viol_sumrdy++;
      if (o_add_a_valid !== o_add_b_valid) viol_pair++;
      if (prev_issue_stall && (o_add_a_valid !== 1'b1 || o_add_a !== prev_a || o_add_b !== prev_b))
         viol_stable++;
      prev_issue_stall = o_add_a_valid && !ardy;
      prev_a = o_add_a;
      prev_b = o_add_b;
      if (prev_out_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_out)) viol_stable++;
      prev_out_stall = o_out_valid && !i_out_ready;
      prev_out = o_out_data;
      if (o_out_valid && !prev_ov) ov_rise_cyc = cyc;
      prev_ov = o_out_valid;
      if (i_add_sum_valid && o_add_sum_ready) void'(aq.pop_front());
      if (o_add_a_valid && ardy) begin
         aq.push_back('{val: real2fp(fp2real(o_add_a) + fp2real(o_add_b)), due: cyc + LAT});
         issues_cur++;
      end
      if (aq.size() > DEPTH) viol_credit++;
      in_fire = i_in_valid && o_in_ready;
      if (in_fire) begin
         if (lasts_acc != outs_done) viol_overlap++;
         if (i_in_last) lasts_acc++;
         acc_cyc = cyc;
      end
      if (o_out_valid && i_out_ready) begin
         got.push_back(o_out_data);
         got_iss.push_back(issues_cur);
         issues_cur = 0;
         outs_done++;
      end
      @(posedge clk);
      @(negedge clk);
      if (in_fire) i_in_valid = 1'b0;
      cyc++;
   endtask

   task automatic run_until(input int n_out, input int budget, input string name);
      int k;
      k = 0;
      while (got.size() < n_out && k < budget) begin
         cycle();
         k++;
      end
      check(name, got.size(), n_out);
   endtask

   task automatic clear_model();
      aq.delete(); src.delete(); got.delete(); got_iss.delete();
      issues_cur = 0; lasts_acc = 0; outs_done = 0;
      prev_issue_stall = 1'b0; prev_out_stall = 1'b0; prev_ov = 1'b0;
      i_in_valid = 1'b0; i_in_last = 1'b0; i_in_data = 32'h0;
      i_add_sum_valid = 1'b0; i_add_sum = 32'h0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},      o_in_ready, 0);
      check({tag, "_add_valid"},     {o_add_a_valid, o_add_b_valid}, 0);
      check({tag, "_add_ab"},        {o_add_a, o_add_b}, 0);
      check({tag, "_out_valid"},     o_out_valid, 0);
      check({tag, "_out_data"},      o_out_data, 0);
      check({tag, "_add_sum_ready"}, o_add_sum_ready, 1);
   endtask

   initial begin
      int k, hold_bad, n, s, v;
      logic [31:0] held;
      clear_model();
      i_add_a_ready = 1'b1; i_add_b_ready = 1'b1; i_out_ready = 1'b1;

      tbl[0] = mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000);
      tbl[1] = mk(4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
      tbl[2] = mk(2, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'h40000000);
      tbl[3] = mk(1, 32'h40000000, 32'h0, 32'h0, 32'h0, 32'h40000000);
      tbl[4] = mk(3, 32'h40400000, 32'h40A00000, 32'h41000000, 32'h0, 32'h41800000);
      tbl[5] = mk(2, 32'hBF800000, 32'h3F800000, 32'h0, 32'h0, 32'h00000000);

      repeat (2) @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      #1 check("reset_release_in_ready", o_in_ready, 1);

      // Single-element frame: bypasses the adder, output two cycles after acceptance.
      src.push_back({1'b1, 32'h3F800000});
      run_until(1, 50, "t1_done");
      check("t1_data", got_at(0), 32'h3F800000);
      check("t1_issues", iss_at(0), 0);
      check("t1_latency", ov_rise_cyc - acc_cyc, 2);
      got.delete(); got_iss.delete();

      // Table frames, streamed back to back.
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < tbl[i].n; j++)
            src.push_back({(j == tbl[i].n - 1), tbl[i].v[j]});
      run_until(6, 600, "tbl_done");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("tbl%0d_sum", i), got_at(i), tbl[i].exp_sum);
         check($sformatf("tbl%0d_issues", i), iss_at(i), tbl[i].n - 1);
      end
      got.delete(); got_iss.delete();

      // 64 x 1.0 with a randomly stalling adder.
      add_rate = 50;
      for (int j = 0; j < 64; j++) src.push_back({(j == 63), 32'h3F800000});
      run_until(1, 3000, "t3_done");
      check("t3_sum", got_at(0), 32'h42800000);
      check("t3_issues", iss_at(0), 63);
      got.delete(); got_iss.delete();
      add_rate = 100;

      // Consumer stall for 10 cycles, then handshake.
      out_rate = 0;
      src.push_back({1'b0, 32'h3F800000});
      src.push_back({1'b1, 32'h40000000});
      k = 0;
      while (!o_out_valid && k < 200) begin cycle(); k++; end
      check("t4_out_valid_seen", o_out_valid, 1);
      held = o_out_data;
      hold_bad = 0;
      for (int j = 0; j < 10; j++) begin
         cycle();
         if (o_out_valid !== 1'b1 || o_out_data !== held || o_in_ready !== 1'b0) hold_bad++;
      end
      check("t4_hold", hold_bad, 0);
      check("t4_held_data", held, 32'h40400000);
      out_rate = 100;
      cycle();
      check("t4_handshake", got.size(), 1);
      check("t4_in_ready_after", o_in_ready, 1);
      got.delete(); got_iss.delete();

      // Random frames against integer sums.
      for (int f = 0; f < 25; f++) begin
         n = $urandom_range(24, 1);
         s = 0;
         for (int j = 0; j < n; j++) begin
            v = $urandom_range(64, 1);
            s += v;
            src.push_back({(j == n - 1), real2fp(real'(v))});
         end
         exp_q.push_back(real2fp(real'(s)));
      end
      k = 0;
      while (got.size() < 25 && k < 30000) begin
         if (k % 64 == 0) begin
            in_rate  = $urandom_range(100, 40);
            add_rate = $urandom_range(100, 30);
            out_rate = $urandom_range(100, 30);
         end
         cycle();
         k++;
      end
      check("rand_done", got.size(), 25);
      for (int i = 0; i < 25; i++) begin
         check($sformatf("rand%0d_sum", i), got_at(i), exp_q[i]);
      end
      got.delete(); got_iss.delete();
      in_rate = 100; add_rate = 100; out_rate = 100;

      // Asynchronous reset in the middle of a 16-element frame.
      for (int j = 0; j < 16; j++) src.push_back({(j == 15), 32'h3F800000});
      repeat (12) cycle();
      #2 rst = 1'b1;
      #1 check_reset_outputs("midreset");
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("midreset_release_in_ready", o_in_ready, 1);
      src.push_back({1'b0, 32'h3F000000});
      src.push_back({1'b1, 32'h3F000000});
      run_until(1, 100, "t6_done");
      check("t6_sum", got_at(0), 32'h3F800000);
      check("t6_issues", iss_at(0), 1);

      check("issue_stable_under_backpressure", viol_stable, 0);
      check("add_valid_pair_equal", viol_pair, 0);
      check("add_sum_ready_always_1", viol_sumrdy, 0);
      check("adds_in_flight_bound", viol_credit, 0);
      check("frames_never_overlap", viol_overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_stream_reducer.md
# fp_stream_reducer

- Reduces a framed stream of floating-point values to a single sum per frame.
- Acts as the initiator side of the pipelined adder handshake:
  - drives `a`/`b` operands into an external `fp_pipeline_adder` instance;
  - consumes that adder's `sum` stream;
  - recirculates partial sums until one value remains.
- Sits between a vector producer (e.g. dot-product lanes) and a scalar consumer, and hides adder latency by keeping several partial additions in flight.

## Interface
- `data_format`, default `FP32`: operand format; width `fp_len = GET_FP_LEN(data_format)`.
- `depth`, default 8: partial-sum return FIFO entries, and the maximum number of adds in flight. Power of two, ≥2.
- `clock` input, 1: single clock; all state on rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state. Shared with the attached adder.
- `in_data` input, fp_len: stream element.
- `in_valid` input, 1: element valid.
- `in_last` input, 1: element is the last of its frame.
- `in_ready` output, 1: element accepted when `in_valid && in_ready`.
- `add_a`, `add_b` output, fp_len: operands to the adder.
- `add_a_valid`, `add_b_valid` output, 1: always equal; the pair is issued together.
- `add_a_ready`, `add_b_ready` input, 1: adder `a_ready`/`b_ready`.
- `add_sum` input, fp_len: adder result.
- `add_sum_valid` input, 1: adder result valid.
- `add_sum_ready` output, 1: result accepted.
- `out_data` output, fp_len: frame sum.
- `out_valid` output, 1: frame sum valid.
- `out_ready` input, 1: consumer ready.

## Operation
**Registered state**
- Operand slots `opA`/`opB`, each with a valid bit.
- Return FIFO of `depth` entries.
- `inflight` counter, `clog2(depth+1)` bits.
- `last_seen` flag.
- FSM with states ACC and OUT.

**Fill**
- Each cycle at most one operand is loaded, into `opA` if empty, else `opB`.
- A slot freed by an issue in the same cycle is not refilled that cycle.
- Source priority: FIFO head first, then the input stream.
- `in_ready = (state==ACC) && !last_seen && fifo_empty && (slot free)`.
  - Derived from registered state only; never depends on `in_valid`.

**Issue**
- `add_*_valid = opA.v && opB.v && (inflight + fifo_count < depth)`.
- Issue fires when valid and both add readies are high.
- On fire: both slots are cleared and `inflight` increments.

**Return**
- `add_sum_ready = !fifo_full`. The credit rule guarantees this is always 1 in normal operation.
- On accept: push to FIFO and decrement `inflight`.
- Issue and return in the same cycle: `inflight` unchanged.

**Completion**
- In ACC, completion requires all of: `last_seen`, `inflight==0`, FIFO empty, exactly one slot valid.
- When met, at the next edge: FSM → OUT, `out_data` ← that slot, slot cleared.
- In OUT:
  - `out_valid=1`, and `out_data` is held stable until `out_ready`.
  - On `out_valid && out_ready`: FSM → ACC, `last_seen` cleared.

**Frame rules**
- A one-element frame (`in_last` on the first element) outputs the element bit-exact, without using the adder.
- Empty frames do not exist.
- Accepting `in_last` sets `last_seen`, which blocks further input until the output handshake completes. Frames never overlap.

**Arithmetic and ordering**
- All arithmetic is done by the adder; NaN/Inf/zero handling is the adder's.
- Summation order is deterministic for a given input timing and backpressure pattern. Results are not guaranteed associative across differing timings.

## Timing
**Reset values**
- `in_ready=0` during reset, and 1 from the first cycle after reset deasserts.
- `add_a`, `add_b`, `out_data` = 0.
- `add_*_valid=0`, `out_valid=0`.
- `add_sum_ready=1`, FIFO empty, `inflight=0`, FSM=ACC, `last_seen=0`.

**Latency and throughput**
- Input accepted at edge t → operand visible in a slot after t → earliest issue at edge t+1 when the partner is present.
- With adder latency L and unbounded `out_ready`, an N-element frame (N≥2) completes in about N + L·ceil(log2 N) + 2 cycles.
- Completion condition true in cycle c → `out_valid` high from cycle c+1.

**Boundary behaviour**
- FIFO full and credit exhausted: issue stalls. Slots stay loaded, no data is lost, and `add_sum_ready` remains high.
- Adder backpressure (`add_a_ready` low): `add_a`/`add_b`/`valid` stay stable until fire.
- Reset asserted mid-frame: all state clears immediately. The adder is reset by the same signal, so no stale sums return.
- Simultaneous FIFO non-empty and `in_valid`: FIFO wins; `in_ready=0`.

## Test plan
1. Single frame [0x3F800000 last] → `out_data`=0x3F800000, `out_valid` high 2 cycles after acceptance; adder never issued.
2. Frame [1.0, 2.0, 3.0, 4.0 last] (0x3F800000, 0x40000000, 0x40400000, 0x40800000) → `out_data`=0x41200000 (10.0); exactly 3 adder issues.
3. 64 × 1.0 with adder `a_ready` toggling randomly → 0x42800000; `inflight + fifo_count` never exceeds 8; `add_sum_ready` always 1.
4. Result ready with `out_ready=0` for 10 cycles → `out_valid` and `out_data` held stable, `in_ready=0`; `out_ready=1` → handshake, `in_ready=1` next cycle.
5. Back-to-back frames [1.0, 1.0 last] then [2.0 last] → outputs 0x40000000, 0x40000000 in order; no element of frame 2 accepted before frame 1 output handshake.
6. Async reset asserted mid-way through a 16-element frame → all outputs at reset values the same cycle; subsequent frame [0.5, 0.5 last] → 0x3F800000.
